// File: rtl/if_id_decode.sv
// if_id_decode: instruction queue + main decode; define IF_ID_ILLEGAL_TRAP_EN to add the illegal-opcode trap
module if_id_decode #(
    parameter int DEPTH = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [31:0] imm_ext,
    output logic        B,
    output logic        jump,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  alu_op
`ifdef IF_ID_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          hold;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;

    assign in_ready   = count != CW'(DEPTH);
    assign out_valid  = count != '0;
    assign push       = in_valid & in_ready & ~flush;
    assign pop        = out_valid & out_ready & ~flush & ~hold;
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

`ifdef IF_ID_ILLEGAL_TRAP_EN
    logic known;
    assign known   = head_instr[31:26] inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
    assign illegal = out_valid & ~known;
    assign hold    = illegal;
`else
    assign hold = 1'b0;
`endif

    // pointers and occupancy; flush wins over any same-cycle push or pop
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // entry storage, deliberately left out of reset
    always_ff @(posedge Clock) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // head decode, every output forced to zero while the queue is empty
    always_comb begin
        {B, jump, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op} = '0;
        out_pc  = out_valid ? head_pc : '0;
        opcode  = out_valid ? head_instr[31:26] : '0;
        rs      = out_valid ? head_instr[25:21] : '0;
        rt      = out_valid ? head_instr[20:16] : '0;
        rd      = out_valid ? head_instr[15:11] : '0;
        funct   = out_valid ? head_instr[5:0] : '0;
        imm_ext = out_valid ? {{16{head_instr[15]}}, head_instr[15:0]} : '0;
        if (out_valid) begin
            case (head_instr[31:26])
                6'b000000: begin reg_dst = 1'b1; reg_write = 1'b1; alu_op = 2'b10; end
                6'b100011: begin alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; mem_read = 1'b1; end
                6'b101011: begin alu_src = 1'b1; mem_write = 1'b1; end
                6'b000100: begin B = 1'b1; alu_op = 2'b01; end
                6'b001000: begin alu_src = 1'b1; reg_write = 1'b1; end
                6'b000010: jump = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_decode.sv
// tb_if_id_decode: scoreboard bench for the instruction queue and decoder
module tb_if_id_decode;
    localparam int DEPTH = 2;

    logic        Clock, Reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, imm_ext;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic        B, jump, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
    logic [1:0]  alu_op;
`ifdef IF_ID_ILLEGAL_TRAP_EN
    logic        illegal;
`endif
    logic [9:0]  ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t q[$];
    int checks = 0;
    int errors = 0;

    if_id_decode #(.DEPTH(DEPTH)) dut (
        .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .funct(funct), .imm_ext(imm_ext), .B(B), .jump(jump),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .alu_op(alu_op)
`ifdef IF_ID_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    assign ctrl = {B, jump, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, alu_op};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // expected {B,jump,reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,alu_op}
    function automatic logic [9:0] exp_ctrl(input logic [31:0] instr);
        case (instr[31:26])
            6'h00:   return 10'b0010010010;
            6'h23:   return 10'b0001111000;
            6'h2b:   return 10'b0001000100;
            6'h04:   return 10'b1000000001;
            6'h08:   return 10'b0001010000;
            6'h02:   return 10'b0100000000;
            default: return 10'b0;
        endcase
    endfunction

    // drive one cycle and advance the scoreboard by what the queue should accept and release
    task automatic tick(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic rdy, input logic fl);
        bit push_ok, pop_ok;
        in_valid = v; in_pc = pc; in_instr = instr; out_ready = rdy; flush = fl;
        push_ok = v && q.size() < DEPTH && !fl;
        pop_ok  = q.size() > 0 && rdy && !fl;
`ifdef IF_ID_ILLEGAL_TRAP_EN
        if (pop_ok && exp_ctrl(q[0].instr) == 10'b0 && q[0].instr[31:26] != 6'h00) pop_ok = 0;
`endif
        @(posedge Clock);
        #1;
        if (fl) q.delete();
        else begin
            if (pop_ok) void'(q.pop_front());
            if (push_ok) q.push_back('{pc, instr});
        end
        in_valid = 0; out_ready = 0; flush = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if ({out_valid, in_ready, ctrl, out_pc} !== {1'b0, 1'b1, 10'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_idle: v=%b rdy=%b ctrl=%b pc=%h, want 0 1 0 0", out_valid, in_ready, ctrl, out_pc);
        end
        Reset = 1'b1;
        tick(1, 32'h10, 32'h8C220004, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || ctrl !== exp_ctrl(32'h8C220004)) begin
            errors++;
            $display("FAIL reset_prefill: v=%b ctrl=%b, want 1 %b", out_valid, ctrl, exp_ctrl(32'h8C220004));
        end
        #2 Reset = 1'b0;
        #1;
        q.delete();
        checks++;
        if ({out_valid, in_ready, ctrl, out_pc, imm_ext, opcode, rs, rt, rd, funct} !== {1'b0, 1'b1, 10'b0, 64'h0, 27'h0}) begin
            errors++;
            $display("FAIL reset_async: v=%b rdy=%b ctrl=%b pc=%h imm=%h rs=%0d rt=%0d, want all idle",
                     out_valid, in_ready, ctrl, out_pc, imm_ext, rs, rt);
        end
        @(negedge Clock) Reset = 1'b1;
        tick(1, 32'h10, 32'h8C220004, 0, 0);
        checks++;
        if ({out_valid, out_pc, rs, rt, imm_ext, ctrl} !== {1'b1, q[0].pc, 5'd1, 5'd2, 32'h4, exp_ctrl(q[0].instr)}) begin
            errors++;
            $display("FAIL reset_repush: v=%b pc=%h rs=%0d rt=%0d imm=%h ctrl=%b, want 1 10 1 2 4 %b",
                     out_valid, out_pc, rs, rt, imm_ext, ctrl, exp_ctrl(q[0].instr));
        end
        tick(0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_beq;
        tick(1, 32'h20, 32'h1022FFFE, 0, 0);
        checks++;
        if ({out_valid, B, alu_op, imm_ext, rs, rt, out_pc} !== {1'b1, 1'b1, 2'b01, 32'hFFFFFFFE, 5'd1, 5'd2, 32'h20}) begin
            errors++;
            $display("FAIL beq_decode: v=%b B=%b op=%b imm=%h rs=%0d rt=%0d pc=%h, want 1 1 01 fffffffe 1 2 20",
                     out_valid, B, alu_op, imm_ext, rs, rt, out_pc);
        end
        checks++;
        if (ctrl !== exp_ctrl(q[0].instr)) begin
            errors++;
            $display("FAIL beq_ctrl: ctrl=%b, want %b", ctrl, exp_ctrl(q[0].instr));
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_fill;
        logic [31:0] ins [3] = '{32'h00221820, 32'hAC220008, 32'h08000010};
        tick(1, 32'h0, ins[0], 0, 0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_one: in_ready=%b, want 1", in_ready);
        end
        tick(1, 32'h4, ins[1], 0, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: in_ready=%b, want 0", in_ready);
        end
        tick(1, 32'h8, ins[2], 0, 0);
        checks++;
        if ({in_ready, out_pc, ctrl} !== {1'b0, q[0].pc, exp_ctrl(q[0].instr)}) begin
            errors++;
            $display("FAIL fill_hold: rdy=%b pc=%h ctrl=%b, want 0 %h %b", in_ready, out_pc, ctrl, q[0].pc, exp_ctrl(q[0].instr));
        end
        tick(1, 32'h8, ins[2], 1, 0);
        checks++;
        if ({in_ready, out_pc, ctrl} !== {1'b1, q[0].pc, exp_ctrl(q[0].instr)}) begin
            errors++;
            $display("FAIL fill_pop: rdy=%b pc=%h ctrl=%b, want 1 %h %b", in_ready, out_pc, ctrl, q[0].pc, exp_ctrl(q[0].instr));
        end
        tick(1, 32'h8, ins[2], 0, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({out_valid, out_pc, ctrl} !== {1'b1, 32'h4 + 32'(4 * i), exp_ctrl(ins[i + 1])}) begin
                errors++;
                $display("FAIL fill_order%0d: v=%b pc=%h ctrl=%b, want 1 %h %b", i, out_valid, out_pc, ctrl,
                         32'h4 + 32'(4 * i), exp_ctrl(ins[i + 1]));
            end
            tick(0, 0, 0, 1, 0);
        end
        checks++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL fill_empty: v=%b model=%0d, want 0 0", out_valid, q.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins [4] = '{32'h20010005, 32'h8C220004, 32'hAC220008, 32'h00221820};
        tick(1, 32'h100, ins[0], 0, 0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({out_valid, in_ready, out_pc, ctrl} !== {1'b1, 1'b1, 32'h100 + 32'(4 * i), exp_ctrl(q[0].instr)}) begin
                errors++;
                $display("FAIL b2b_%0d: v=%b rdy=%b pc=%h ctrl=%b, want 1 1 %h %b", i, out_valid, in_ready, out_pc, ctrl,
                         32'h100 + 32'(4 * i), exp_ctrl(q[0].instr));
            end
            tick(1, 32'h104 + 32'(4 * i), ins[(i + 1) % 4], 1, 0);
        end
        checks++;
        if ({out_valid, out_pc} !== {1'b1, q[0].pc} || q.size() != 1) begin
            errors++;
            $display("FAIL b2b_end: v=%b pc=%h, want 1 %h", out_valid, out_pc, q[0].pc);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_flush;
        tick(1, 32'h200, 32'h20010001, 0, 0);
        tick(1, 32'h204, 32'h20010002, 0, 0);
        tick(1, 32'h208, 32'h20010003, 1, 1);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_full: v=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        tick(1, 32'h300, 32'h20010004, 0, 0);
        tick(1, 32'h304, 32'h20010005, 0, 1);
        checks++;
        if ({out_valid, in_ready, out_pc} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL flush_push: v=%b rdy=%b pc=%h, want 0 1 0", out_valid, in_ready, out_pc);
        end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_ghost: v=%b pc=%h, want 0", out_valid, out_pc);
        end
    endtask

    task automatic test_illegal;
        tick(1, 32'h40, 32'hFC000000, 0, 0);
        checks++;
        if ({out_valid, ctrl, opcode} !== {1'b1, 10'b0, 6'h3F}) begin
            errors++;
            $display("FAIL illegal_decode: v=%b ctrl=%b op=%h, want 1 0 3f", out_valid, ctrl, opcode);
        end
`ifdef IF_ID_ILLEGAL_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({illegal, out_valid, out_pc} !== {1'b1, 1'b1, 32'h40}) begin
                errors++;
                $display("FAIL illegal_hold%0d: ill=%b v=%b pc=%h, want 1 1 40", i, illegal, out_valid, out_pc);
            end
            tick(0, 0, 0, 1, 0);
        end
        tick(0, 0, 0, 1, 1);
        checks++;
        if ({illegal, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL illegal_flush: ill=%b v=%b, want 0 0", illegal, out_valid);
        end
`else
        tick(0, 0, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pop: v=%b, want 0", out_valid);
        end
`endif
    endtask

    initial begin
        Reset = 1'b0; in_valid = 0; in_pc = 0; in_instr = 0; flush = 0; out_ready = 0;
        test_reset;
        test_beq;
        test_fill;
        test_back_to_back;
        test_flush;
        test_illegal;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_decode.md
# if_id_decode

Instruction queue and decode stage sitting directly downstream of the fetch stage. It accepts {PC, instruction} pairs through a valid/ready handshake and buffers them in a small FIFO. It decodes the head entry into register fields, a sign-extended immediate and main-control signals. The sign-extended immediate and the branch flag feed back to fetch as its branch-offset and branch inputs.

## Interface
- DEPTH, 2: FIFO entries; power of two, 2..8.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low; clock Clock.
- in_valid  in  1  fetch presents a valid pair.
- in_ready  out  1  queue can accept; equals (count != DEPTH).
- in_pc  in  32  PC of the presented instruction.
- in_instr  in  32  instruction word.
- flush  in  1  discard all buffered and incoming entries.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  downstream consumes head this cycle.
- out_pc  out  32  PC of head entry.
- opcode  out  6  instr[31:26].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- funct  out  6  instr[5:0].
- imm_ext  out  32  instr[15:0] sign-extended; drives fetch branch-offset input, unshifted.
- B  out  1  head is beq.
- jump, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write  out  1 each  main control.
- alu_op  out  2  00 add, 01 sub, 10 R-type funct.
- illegal  out  1  unknown opcode at head; present only with the macro.

## Operation
- Storage: DEPTH entries of {pc, instr}, write pointer, read pointer and count. Width is log2(DEPTH)+1 for count; pointers wrap modulo DEPTH.
- Push: in_valid & in_ready & !flush at a rising edge. The pair is written at wr_ptr, and wr_ptr advances.
- Pop: out_valid & out_ready & !flush at a rising edge. rd_ptr advances.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged. When full, in_ready=0, so no push occurs; same-cycle pop does not make room combinationally.
- Flush, checked before push and pop: pointers and count go to 0 at the edge. Any same-cycle push or pop is ignored.
- Decode is combinational from the head entry:
  - R-type 000000: reg_dst=1, reg_write=1, alu_op=10.
  - lw 100011: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - sw 101011: alu_src=1, mem_write=1, alu_op=00.
  - beq 000100: B=1, alu_op=01.
  - addi 001000: alu_src=1, reg_write=1, alu_op=00.
  - j 000010: jump=1.
  - Any other opcode: all control signals 0.
- While out_valid=0, every decoded output, out_pc and imm_ext are forced to 0.
- Reset, asynchronous and honoured mid-operation: pointers and count go to 0, so in_ready=1 and out_valid=0. All decoded outputs are therefore 0. FIFO contents are not cleared.

## Timing
- Latency: a pair pushed at edge k appears at the head after edge k when the queue was empty; out_valid rises in the cycle following edge k.
- in_ready and out_valid are derived from registered count only. There is no combinational path from in_valid or out_ready to them.
- Decoded outputs change only after an edge; they are stable for the whole cycle.
- Flush asserted in cycle n gives out_valid=0 and in_ready=1 in cycle n+1.
- Throughput is one pair per cycle while 0 < count < DEPTH.

## Configuration
- IF_ID_ILLEGAL_TRAP_EN defined:
  - Port illegal exists and equals out_valid & (opcode not in the six listed).
  - While illegal=1, head pops are blocked regardless of out_ready, so the queue holds. Only flush or Reset clears it.
- IF_ID_ILLEGAL_TRAP_EN undefined:
  - No illegal port.
  - Unknown opcodes decode to all-zero control and pop normally.

## Test plan
- Reset mid-fill: push 0x8C220004 (lw) at pc 0x10, then pull Reset low between edges. Required: out_valid=0, in_ready=1 and all decoded outputs 0 immediately. After release, first push appears one cycle later.
- Push beq 0x1022FFFE at pc 0x20 with out_ready=0. Required, next cycle: out_valid=1, B=1, alu_op=01, imm_ext=0xFFFFFFFE, rs=1, rt=2, out_pc=0x20.
- DEPTH=2 fill: push 3 pairs back-to-back with out_ready=0. Required: in_ready=0 after the second push, and the third pair is held. After one pop, in_ready=1 next cycle; output order pc 0x0, 0x4, 0x8.
- Simultaneous push and pop at count=1 for 6 cycles. Required: count stays 1, out_pc advances by 4 each cycle, and pointers wrap correctly.
- flush with a same-cycle push while count=2. Required: next cycle out_valid=0 and in_ready=1; the pushed pair never appears.
- With IF_ID_ILLEGAL_TRAP_EN defined: push 0xFC000000. Required: illegal=1, all control 0, and the head is held for 5 cycles with out_ready=1. flush clears it. Without the macro, it pops after one cycle.
